// File: rtl/apb_master.sv
`default_nettype none
// ============================================================================
// Module      : apb_master
// Description : APB requester. Converts one valid/ready command at a time into
//               an APB SETUP/ACCESS transfer, waits for pready (bounded by a
//               wait-state timeout) and returns read data or an abort flag on
//               a valid/ready response port.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_master #(
  parameter int DATA_WD = 8,
  parameter int ADDR_WD = 8,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  // command port
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_write,
  input  logic [ADDR_WD-1:0] cmd_addr,
  input  logic [DATA_WD-1:0] cmd_wdata,
  // response port
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DATA_WD-1:0] rsp_rdata,
  output logic               rsp_err,
  // APB requester interface
  output logic               psel,
  output logic               penable,
  output logic               pwrite,
  output logic [ADDR_WD-1:0] paddr,
  output logic [DATA_WD-1:0] pwdata,
  input  logic [DATA_WD-1:0] prdata,
  input  logic               pready
);

  // Counter only has to reach TIMEOUT-1; keep at least one bit so it exists
  // even when the timeout is disabled or trivially small.
  localparam int CNT_WD = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_WD-1:0] C_CNT_LAST = CNT_WD'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t              state_q;
  logic                psel_q;
  logic                penable_q;
  logic                pwrite_q;
  logic [ADDR_WD-1:0]  paddr_q;
  logic [DATA_WD-1:0]  pwdata_q;
  logic                rsp_valid_q;
  logic [DATA_WD-1:0]  rsp_rdata_q;
  logic                rsp_err_q;
  logic [CNT_WD-1:0]   wait_cnt_q;
  logic                timeout_hit;

  // Abort fires in the N-th consecutive ACCESS cycle without pready.
  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt_q == C_CNT_LAST);

  // Only IDLE can take a command, so no command/response overlap is possible.
  assign cmd_ready = (state_q == ST_IDLE);

  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  // Transfer sequencer with all bus and response outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      wait_cnt_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            // Address/control captured here stay frozen until the next accept.
            pwrite_q   <= cmd_write;
            paddr_q    <= cmd_addr;
            pwdata_q   <= cmd_wdata;
            psel_q     <= 1'b1;
            penable_q  <= 1'b0;
            wait_cnt_q <= '0;
            state_q    <= ST_SETUP;
          end else begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
          end
        end

        ST_SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ST_ACCESS;
        end

        ST_ACCESS: begin
          if (pready) begin
            // A ready slave wins even in the cycle the timeout would fire.
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= pwrite_q ? '0 : prdata;
            state_q     <= ST_RESP;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
            if (timeout_hit) begin
              psel_q      <= 1'b0;
              penable_q   <= 1'b0;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
              state_q     <= ST_RESP;
            end
          end
        end

        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end

        default: begin
          state_q     <= ST_IDLE;
          psel_q      <= 1'b0;
          penable_q   <= 1'b0;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_master
// Description : Directed self-checking bench for apb_master with a small APB
//               memory slave that inserts a programmable number of wait states.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_master;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata;
  logic          pready;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int proto_err = 0;

  // slave model controls
  logic [DW-1:0] mem [256];
  int   acc_cnt = 0;
  int   wait_n = 0;
  logic force_en = 1'b0;
  logic force_val = 1'b0;

  always #5 clk = ~clk;

  apb_master #(.DATA_WD(DW), .ADDR_WD(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready)
  );

  // memory slave: ready after wait_n stalled ACCESS cycles, or forced level
  assign pready = force_en ? force_val : (psel && penable && (acc_cnt == wait_n));
  assign prdata = mem[paddr];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
    if (psel && penable && pready && pwrite) mem[paddr] <= pwdata;
  end

  // APB protocol monitor
  logic          prev_psel = 1'b0;
  logic          prev_wr = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [DW-1:0] prev_wd = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      proto_err <= proto_err
                 + ((penable && !psel) ? 1 : 0)
                 + ((psel && rsp_valid) ? 1 : 0)
                 + ((penable && !prev_psel) ? 1 : 0)
                 + ((prev_psel && psel && (paddr !== prev_addr || pwrite !== prev_wr ||
                                           pwdata !== prev_wd)) ? 1 : 0);
    end
    prev_psel <= psel;
    prev_wr   <= pwrite;
    prev_addr <= paddr;
    prev_wd   <= pwdata;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a command and return right after the accepting edge (in SETUP).
  task automatic issue_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int k = 0;
    cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
    while (!cmd_ready && k < 20) begin step(); k++; end
    step();
    cmd_valid = 1'b0;
    cmd_addr = 8'hFF; cmd_wdata = 8'h00; cmd_write = ~w;
  endtask

  // Count bus cycles until rsp_valid; lat counts from the accept cycle (= 0).
  task automatic wait_rsp(output int psel_cyc, output int pen_cyc, output int lat, output bit to);
    psel_cyc = 0; pen_cyc = 0; lat = 1;
    while (!rsp_valid && lat < 40) begin
      if (psel) psel_cyc++;
      if (penable) pen_cyc++;
      step();
      lat++;
    end
    to = !rsp_valid;
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    vectors++;
    if ({psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err, cmd_ready} !== {3'b000, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_outputs: got psel=%b pen=%b pw=%b pa=%h pwd=%h rv=%b rd=%h re=%b cr=%b want all 0, cmd_ready=1",
               psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err, cmd_ready);
    end
    rst_n = 1'b1;
    step();
    vectors++;
    if ({psel, rsp_valid, cmd_ready} !== 3'b001) begin
      miscompares++;
      $display("FAIL reset_release_idle: got psel=%b rv=%b cr=%b want 0 0 1", psel, rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_write();
    wait_n = 0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h10; cmd_wdata = 8'hA5;
    vectors++;
    if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL write_cmd_ready: got %b want 1", cmd_ready); end
    step();
    cmd_valid = 1'b0; cmd_addr = 8'hFF; cmd_wdata = 8'h00; cmd_write = 1'b0;
    vectors++;
    if ({psel, penable, pwrite, paddr, pwdata, rsp_valid} !== {3'b101, 8'h10, 8'hA5, 1'b0}) begin
      miscompares++;
      $display("FAIL write_setup: got psel=%b pen=%b pw=%b pa=%h pwd=%h rv=%b want 1 0 1 10 a5 0",
               psel, penable, pwrite, paddr, pwdata, rsp_valid);
    end
    step();
    vectors++;
    if ({psel, penable, pwrite, paddr, pwdata, rsp_valid} !== {3'b111, 8'h10, 8'hA5, 1'b0}) begin
      miscompares++;
      $display("FAIL write_access: got psel=%b pen=%b pw=%b pa=%h pwd=%h rv=%b want 1 1 1 10 a5 0",
               psel, penable, pwrite, paddr, pwdata, rsp_valid);
    end
    step();
    vectors++;
    if ({psel, penable, rsp_valid, rsp_err, rsp_rdata, cmd_ready} !== {4'b0010, 8'h00, 1'b0}) begin
      miscompares++;
      $display("FAIL write_resp_cycle3: got psel=%b pen=%b rv=%b re=%b rd=%h cr=%b want 0 0 1 0 00 0",
               psel, penable, rsp_valid, rsp_err, rsp_rdata, cmd_ready);
    end
    take_rsp();
    vectors++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL write_rsp_consumed: got rv=%b cr=%b want 0 1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_read_wait();
    int pc, ec, lat; bit to;
    wait_n = 1;
    issue_cmd(1'b0, 8'h10, 8'h00);
    wait_rsp(pc, ec, lat, to);
    vectors++;
    if (to || ec != 2 || lat != 4 || rsp_rdata !== 8'hA5 || rsp_err !== 1'b0) begin
      miscompares++;
      $display("FAIL read_wait1: got to=%0d access=%0d lat=%0d rd=%h re=%b want 0 2 4 a5 0",
               to, ec, lat, rsp_rdata, rsp_err);
    end
    take_rsp();
    wait_n = 0;
  endtask

  task automatic test_timeout();
    int pc, ec, lat; bit to;
    force_en = 1'b1; force_val = 1'b0;
    issue_cmd(1'b0, 8'h10, 8'h00);
    wait_rsp(pc, ec, lat, to);
    vectors++;
    if (to || pc != 5 || ec != 4 || lat != 6) begin
      miscompares++;
      $display("FAIL timeout_cycles: got to=%0d psel=%0d access=%0d lat=%0d want 0 5 4 6", to, pc, ec, lat);
    end
    vectors++;
    if ({psel, penable, rsp_err, rsp_rdata} !== {3'b001, 8'h00}) begin
      miscompares++;
      $display("FAIL timeout_resp: got psel=%b pen=%b re=%b rd=%h want 0 0 1 00", psel, penable, rsp_err, rsp_rdata);
    end
    take_rsp();
    force_en = 1'b0;
    // ready arriving in the last allowed ACCESS cycle completes normally
    wait_n = 3;
    issue_cmd(1'b0, 8'h10, 8'h00);
    wait_rsp(pc, ec, lat, to);
    vectors++;
    if (to || ec != 4 || rsp_err !== 1'b0 || rsp_rdata !== 8'hA5) begin
      miscompares++;
      $display("FAIL timeout_ready_last: got to=%0d access=%0d re=%b rd=%h want 0 4 0 a5", to, ec, rsp_err, rsp_rdata);
    end
    take_rsp();
    wait_n = 0;
  endtask

  task automatic test_backpressure();
    int pc, ec, lat; bit to;
    issue_cmd(1'b1, 8'h22, 8'h3C);
    wait_rsp(pc, ec, lat, to);
    vectors++;
    if (to) begin miscompares++; $display("FAIL bp_rsp_arrive: got timeout want response"); end
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h22; cmd_wdata = 8'h00;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if ({rsp_valid, rsp_rdata, rsp_err, cmd_ready, psel} !== {1'b1, 8'h00, 3'b000}) begin
        miscompares++;
        $display("FAIL bp_hold_%0d: got rv=%b rd=%h re=%b cr=%b psel=%b want 1 00 0 0 0",
                 i, rsp_valid, rsp_rdata, rsp_err, cmd_ready, psel);
      end
      step();
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    vectors++;
    if ({rsp_valid, cmd_ready, psel} !== 3'b010) begin
      miscompares++;
      $display("FAIL bp_release: got rv=%b cr=%b psel=%b want 0 1 0", rsp_valid, cmd_ready, psel);
    end
    step();
    cmd_valid = 1'b0;
    vectors++;
    if ({psel, penable, pwrite, paddr} !== {3'b100, 8'h22}) begin
      miscompares++;
      $display("FAIL bp_next_accept: got psel=%b pen=%b pw=%b pa=%h want 1 0 0 22", psel, penable, pwrite, paddr);
    end
    wait_rsp(pc, ec, lat, to);
    vectors++;
    if (to || rsp_rdata !== 8'h3C) begin
      miscompares++;
      $display("FAIL bp_readback: got to=%0d rd=%h want 0 3c", to, rsp_rdata);
    end
    take_rsp();
  endtask

  task automatic test_reset_mid();
    force_en = 1'b1; force_val = 1'b0;
    issue_cmd(1'b1, 8'h33, 8'h77);
    step();
    vectors++;
    if ({psel, penable} !== 2'b11) begin
      miscompares++;
      $display("FAIL rstmid_in_access: got psel=%b pen=%b want 1 1", psel, penable);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    vectors++;
    if ({psel, penable, rsp_valid, cmd_ready, paddr} !== {4'b0001, 8'h00}) begin
      miscompares++;
      $display("FAIL rstmid_idle: got psel=%b pen=%b rv=%b cr=%b pa=%h want 0 0 0 1 00",
               psel, penable, rsp_valid, cmd_ready, paddr);
    end
    step(); step();
    vectors++;
    if ({psel, rsp_valid, cmd_ready} !== 3'b001) begin
      miscompares++;
      $display("FAIL rstmid_no_rsp: got psel=%b rv=%b cr=%b want 0 0 1", psel, rsp_valid, cmd_ready);
    end
    force_en = 1'b0;
  endtask

  task automatic test_pready_idle();
    force_en = 1'b1; force_val = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if ({psel, penable, rsp_valid, cmd_ready} !== 4'b0001) begin
        miscompares++;
        $display("FAIL pready_idle_%0d: got psel=%b pen=%b rv=%b cr=%b want 0 0 0 1",
                 i, psel, penable, rsp_valid, cmd_ready);
      end
    end
    force_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic          bw [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [AW-1:0] ba [8] = '{8'h40, 8'h41, 8'h40, 8'h40, 8'h41, 8'h40, 8'h10, 8'h42};
    logic [DW-1:0] bd [8] = '{8'h11, 8'h22, 8'h00, 8'h99, 8'h00, 8'h00, 8'h00, 8'h5A};
    logic [DW-1:0] be [8] = '{8'h00, 8'h00, 8'h11, 8'h00, 8'h22, 8'h99, 8'hA5, 8'h00};
    int acc [8];
    wait_n = 0;
    rsp_ready = 1'b1;
    cmd_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      int k = 0;
      cmd_write = bw[i]; cmd_addr = ba[i]; cmd_wdata = bd[i];
      while (!cmd_ready && k < 20) begin step(); k++; end
      acc[i] = cyc;
      step();
      k = 0;
      while (!rsp_valid && k < 20) begin step(); k++; end
      vectors++;
      if (!rsp_valid || rsp_rdata !== be[i] || rsp_err !== 1'b0) begin
        miscompares++;
        $display("FAIL b2b_rsp_%0d: got rv=%b rd=%h re=%b want 1 %h 0", i, rsp_valid, rsp_rdata, rsp_err, be[i]);
      end
      if (i > 0) begin
        vectors++;
        if (acc[i] - acc[i-1] != 4) begin
          miscompares++;
          $display("FAIL b2b_rate_%0d: got interval %0d want 4", i, acc[i] - acc[i-1]);
        end
      end
      step();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    step();
    vectors++;
    if (proto_err != 0) begin
      miscompares++;
      $display("FAIL apb_protocol: got %0d violations want 0", proto_err);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    test_pready_idle();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
